// File: rtl/counter_timer_pkg.sv
// Shared constants for counter_timer_nch: channel mode encodings and control-word field positions.
package counter_timer_pkg;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_SQUARE   = 2'd2;
  localparam logic [1:0] MODE_FREERUN  = 2'd3;

  localparam int unsigned CTRL_MODE_LSB = 0;
  localparam int unsigned CTRL_EN_BIT   = 2;
  localparam int unsigned CTRL_MASK_BIT = 3;
  localparam int unsigned CTRL_DIV_LSB  = 4;

endpackage

// File: rtl/counter_timer_chan.sv
// One timer channel: prescaler, count/reload, OUT line and optional sticky
// interrupt pend bit (present when COUNTER_IRQ_EN is defined).
module counter_timer_chan
  import counter_timer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_we,
  input  logic             ctrl_we,
  input  logic [WIDTH-1:0] wr_val,
  output logic [WIDTH-1:0] count,
  output logic             out,
  output logic             irq_req
);

  localparam int CTRL_W = PRESC_W + 4;

  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   reload_q, reload_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               out_q, out_d;

  logic [1:0]         mode;
  logic               en;
  logic [PRESC_W-1:0] div;
  logic               tick;
  logic               event_hit;

  always_comb begin
    mode      = ctrl_q[CTRL_MODE_LSB +: 2];
    en        = ctrl_q[CTRL_EN_BIT];
    div       = ctrl_q[CTRL_DIV_LSB +: PRESC_W];
    tick      = en && (pcnt_q == div);

    count_d   = count_q;
    reload_d  = reload_q;
    ctrl_d    = ctrl_q;
    pcnt_d    = pcnt_q;
    out_d     = out_q;
    event_hit = 1'b0;

    // A bus write always takes priority; any coincident tick is discarded.
    if (load_we) begin
      reload_d = wr_val;
      count_d  = wr_val;
      pcnt_d   = '0;
      out_d    = 1'b0;
    end else if (ctrl_we) begin
      ctrl_d = wr_val[CTRL_W-1:0];
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
      if (mode == MODE_PERIODIC || mode == MODE_FREERUN) begin
        out_d = 1'b0;
      end
      if (tick) begin
        if (mode == MODE_FREERUN) begin
          if (count_q == '1) begin
            count_d   = '0;
            out_d     = 1'b1;
            event_hit = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else if (count_q == WIDTH'(1)) begin
          event_hit = 1'b1;
          case (mode)
            MODE_ONESHOT: begin
              count_d = '0;
              out_d   = 1'b1;
            end
            MODE_PERIODIC: begin
              count_d = reload_q;
              out_d   = 1'b1;
            end
            default: begin
              count_d = reload_q;
              out_d   = ~out_q;
            end
          endcase
        end else if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      reload_q <= '0;
      ctrl_q   <= '0;
      pcnt_q   <= '0;
      out_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      ctrl_q   <= ctrl_d;
      pcnt_q   <= pcnt_d;
      out_q    <= out_d;
    end
  end

  assign count = count_q;
  assign out   = out_q;

`ifdef COUNTER_IRQ_EN
  logic pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (ctrl_we) pend_d = 1'b0;
    if (event_hit) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end

  assign irq_req = pend_q & ctrl_q[CTRL_MASK_BIT];
`else
  logic irq_unused;
  assign irq_unused = ctrl_q[CTRL_MASK_BIT] ^ event_hit;
  assign irq_req    = 1'b0;
`endif

endmodule

// File: rtl/counter_timer_nch.sv
// N-channel timer/counter peripheral: bus write decode, per-channel instances,
// count readback mux and irq OR. Interrupt pend logic enabled by COUNTER_IRQ_EN.
module counter_timer_nch
  import counter_timer_pkg::*;
#(
  parameter int  NCH     = 3,
  parameter int  WIDTH   = 32,
  parameter int  PRESC_W = 12,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             counter_we,
  input  logic [CH_W-1:0]  counter_ch,
  input  logic             counter_ctrl,
  input  logic [WIDTH-1:0] counter_val,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [WIDTH-1:0] counter_out,
  output logic [NCH-1:0]   counter_OUT,
  output logic             irq
);

  logic [WIDTH-1:0] count_all [NCH];
  logic [NCH-1:0]   irq_vec;
  logic [NCH-1:0]   load_we;
  logic [NCH-1:0]   ctrl_we;

  // Channel indices >= NCH never match, so such writes fall on the floor.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign load_we[g] = counter_we && !counter_ctrl && (counter_ch == CH_W'(g));
    assign ctrl_we[g] = counter_we &&  counter_ctrl && (counter_ch == CH_W'(g));

    counter_timer_chan #(
      .WIDTH   (WIDTH),
      .PRESC_W (PRESC_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .load_we (load_we[g]),
      .ctrl_we (ctrl_we[g]),
      .wr_val  (counter_val),
      .count   (count_all[g]),
      .out     (counter_OUT[g]),
      .irq_req (irq_vec[g])
    );
  end

  always_comb begin
    counter_out = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rd_ch == CH_W'(i)) counter_out = count_all[i];
    end
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_counter_timer_nch.sv
// Directed, table-driven bench for counter_timer_nch (3 channels, 32-bit).
module tb_counter_timer_nch;

  localparam int NCH     = 3;
  localparam int WIDTH   = 32;
  localparam int PRESC_W = 12;
  localparam int CH_W    = 2;
`ifdef COUNTER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             counter_we;
  logic [CH_W-1:0]  counter_ch;
  logic             counter_ctrl;
  logic [WIDTH-1:0] counter_val;
  logic [CH_W-1:0]  rd_ch;
  logic [WIDTH-1:0] counter_out;
  logic [NCH-1:0]   counter_OUT;
  logic             irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  counter_timer_nch #(
    .NCH     (NCH),
    .WIDTH   (WIDTH),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .counter_we   (counter_we),
    .counter_ch   (counter_ch),
    .counter_ctrl (counter_ctrl),
    .counter_val  (counter_val),
    .rd_ch        (rd_ch),
    .counter_out  (counter_out),
    .counter_OUT  (counter_OUT),
    .irq          (irq)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic        ctrl;
    logic [1:0]  ch;
    logic [31:0] val;
    logic [1:0]  rd;
    logic [31:0] exp_cnt;
    logic [2:0]  exp_out;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic we, input logic c,
                              input logic [1:0] ch, input logic [31:0] val,
                              input logic [1:0] rd, input logic [31:0] ec,
                              input logic [2:0] eo);
    vec_t v;
    v.rst = r; v.we = we; v.ctrl = c; v.ch = ch; v.val = val;
    v.rd = rd; v.exp_cnt = ec; v.exp_out = eo;
    vq.push_back(v);
  endfunction

  function automatic void ld(input logic [1:0] ch, input logic [31:0] val,
                             input logic [1:0] rd, input logic [31:0] ec,
                             input logic [2:0] eo);
    add(1'b0, 1'b1, 1'b0, ch, val, rd, ec, eo);
  endfunction

  function automatic void cw(input logic [1:0] ch, input logic [31:0] val,
                             input logic [1:0] rd, input logic [31:0] ec,
                             input logic [2:0] eo);
    add(1'b0, 1'b1, 1'b1, ch, val, rd, ec, eo);
  endfunction

  function automatic void idle(input logic [1:0] rd, input logic [31:0] ec,
                               input logic [2:0] eo);
    add(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, rd, ec, eo);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic write_reg(input logic c, input logic [1:0] ch, input logic [31:0] val);
    counter_we = 1'b1; counter_ctrl = c; counter_ch = ch; counter_val = val;
    @(posedge clk); #1;
    counter_we = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;

    // Test 1: one-shot ch0, load 5, enable div 0
    ld  (2'd0, 32'd5,   2'd0, 32'd5, 3'b000);
    cw  (2'd0, 32'h4,   2'd0, 32'd5, 3'b000);
    idle(2'd0, 32'd4, 3'b000);
    idle(2'd0, 32'd3, 3'b000);
    idle(2'd0, 32'd2, 3'b000);
    idle(2'd0, 32'd1, 3'b000);
    idle(2'd0, 32'd0, 3'b001);
    idle(2'd0, 32'd0, 3'b001);
    idle(2'd0, 32'd0, 3'b001);
    ld  (2'd0, 32'd0,   2'd0, 32'd0, 3'b000);
    // Test 2: periodic ch1, reload 3, div 1
    ld  (2'd1, 32'd3,   2'd1, 32'd3, 3'b000);
    cw  (2'd1, 32'h15,  2'd1, 32'd3, 3'b000);
    idle(2'd1, 32'd3, 3'b000);
    idle(2'd1, 32'd2, 3'b000);
    idle(2'd1, 32'd2, 3'b000);
    idle(2'd1, 32'd1, 3'b000);
    idle(2'd1, 32'd1, 3'b000);
    idle(2'd1, 32'd3, 3'b010);
    idle(2'd1, 32'd3, 3'b000);
    idle(2'd1, 32'd2, 3'b000);
    idle(2'd1, 32'd2, 3'b000);
    idle(2'd1, 32'd1, 3'b000);
    idle(2'd1, 32'd1, 3'b000);
    idle(2'd1, 32'd3, 3'b010);
    idle(2'd1, 32'd3, 3'b000);
    cw  (2'd1, 32'h0,   2'd1, 32'd3, 3'b000);
    // Test 3: square ch2, reload 4, div 0
    ld  (2'd2, 32'd4,   2'd2, 32'd4, 3'b000);
    cw  (2'd2, 32'h6,   2'd2, 32'd4, 3'b000);
    idle(2'd2, 32'd3, 3'b000);
    idle(2'd2, 32'd2, 3'b000);
    idle(2'd2, 32'd1, 3'b000);
    idle(2'd2, 32'd4, 3'b100);
    idle(2'd2, 32'd3, 3'b100);
    idle(2'd2, 32'd2, 3'b100);
    idle(2'd2, 32'd1, 3'b100);
    idle(2'd2, 32'd4, 3'b000);
    idle(2'd2, 32'd3, 3'b000);
    idle(2'd2, 32'd2, 3'b000);
    idle(2'd2, 32'd1, 3'b000);
    idle(2'd2, 32'd4, 3'b100);
    ld  (2'd2, 32'd0,   2'd2, 32'd0, 3'b000);
    // Test 4: free-run ch0 near wrap
    ld  (2'd0, 32'hFFFF_FFFE, 2'd0, 32'hFFFF_FFFE, 3'b000);
    cw  (2'd0, 32'h7,         2'd0, 32'hFFFF_FFFE, 3'b000);
    idle(2'd0, 32'hFFFF_FFFF, 3'b000);
    idle(2'd0, 32'h0, 3'b001);
    idle(2'd0, 32'h1, 3'b000);
    idle(2'd0, 32'h2, 3'b000);
    // Test 5: write coincident with tick, out-of-range channel, cross-channel write
    ld  (2'd0, 32'h10,  2'd0, 32'h10, 3'b000);
    idle(2'd0, 32'h11, 3'b000);
    cw  (2'd0, 32'h7,   2'd0, 32'h11, 3'b000);
    idle(2'd0, 32'h12, 3'b000);
    ld  (2'd3, 32'h55,  2'd3, 32'h0,  3'b000);
    idle(2'd0, 32'h14, 3'b000);
    ld  (2'd1, 32'd7,   2'd0, 32'h15, 3'b000);
    idle(2'd1, 32'd7, 3'b000);
    ld  (2'd2, 32'd1,   2'd2, 32'd1, 3'b000);
    cw  (2'd2, 32'h4,   2'd2, 32'd1, 3'b000);
    idle(2'd2, 32'd0, 3'b100);
    add (1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 32'd0, 3'b000);
    idle(2'd1, 32'd0, 3'b000);
    idle(2'd2, 32'd0, 3'b000);
    idle(2'd0, 32'd0, 3'b000);

    rst = 1'b1; counter_we = 1'b0; counter_ctrl = 1'b0;
    counter_ch = '0; counter_val = '0; rd_ch = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset count", counter_out, 32'd0);
    check("reset OUT", 32'(counter_OUT), 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; counter_we = vq[i].we; counter_ctrl = vq[i].ctrl;
      counter_ch = vq[i].ch; counter_val = vq[i].val; rd_ch = vq[i].rd;
      @(posedge clk); #1;
      check($sformatf("vec%0d count", i), counter_out, vq[i].exp_cnt);
      check($sformatf("vec%0d OUT", i), 32'(counter_OUT), 32'(vq[i].exp_out));
      check($sformatf("vec%0d irq", i), 32'(irq), 32'd0);
    end
    rst = 1'b0; counter_we = 1'b0;

    // Prescaler div 3, one-shot from 2: OUT[1] rises 8 cycles after enable
    rd_ch = 2'd1;
    write_reg(1'b0, 2'd1, 32'd2);
    write_reg(1'b1, 2'd1, 32'h34);
    cycles = 0;
    while (cycles < 20 && counter_OUT[1] !== 1'b1) begin
      cycle();
      cycles++;
    end
    check("presc div3 latency", 32'(cycles), 32'd8);
    check("presc div3 count", counter_out, 32'd0);

    // Interrupt: masked one-shot expire, clear by ctrl write, unmasked stays low
    rd_ch = 2'd0;
    write_reg(1'b0, 2'd0, 32'd2);
    write_reg(1'b1, 2'd0, 32'hC);
    check("irq before expire", 32'(irq), 32'd0);
    cycle();
    check("irq before expire 2", 32'(irq), 32'd0);
    cycle();
    check("irq on expire", 32'(irq), 32'(IRQ_ON));
    check("OUT0 on expire", 32'(counter_OUT[0]), 32'd1);
    cycle();
    check("irq sticky", 32'(irq), 32'(IRQ_ON));
    write_reg(1'b1, 2'd0, 32'hC);
    check("irq cleared", 32'(irq), 32'd0);
    write_reg(1'b0, 2'd0, 32'd1);
    write_reg(1'b1, 2'd0, 32'h4);
    cycle();
    check("irq mask0 OUT", 32'(counter_OUT[0]), 32'd1);
    check("irq mask0", 32'(irq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
